// File: rtl/mfp_uart_pkg.sv
// rtl/mfp_uart_pkg.sv - shared UART constants, bit-FSM encoding and divider helper
package mfp_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Clock cycles per serial bit; integer truncation is intentional.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/mfp_uart_fifo.sv
// rtl/mfp_uart_fifo.sv - synchronous byte FIFO with wrap-bit full detection
module mfp_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/mfp_uart_transmitter.sv
// rtl/mfp_uart_transmitter.sv - buffered 8N1 UART transmitter
module mfp_uart_transmitter
    import mfp_uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int DIV   = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("mfp_uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       push;
    logic       pop;

    // A byte is popped when the line is free: from idle, or at the last cycle of a stop bit.
    assign push = !reset && tx_valid && !fifo_full;
    assign pop  = !reset && !fifo_empty &&
                  ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == '0)));

    assign tx_ready = !fifo_full;
    assign busy     = (state != ST_IDLE) || !fifo_empty;

    mfp_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bit FSM and baud counter; tx is registered from the current state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_START: tx <= 1'b0;
                ST_DATA:  tx <= shreg[0];
                default:  tx <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state    <= ST_START;
                        shreg    <= fifo_rdata;
                        baud_cnt <= DIV_M1;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        state    <= ST_DATA;
                        baud_cnt <= DIV_M1;
                        bit_idx  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= DIV_M1;
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0) begin
                        if (pop) begin
                            state    <= ST_START;
                            shreg    <= fifo_rdata;
                            baud_cnt <= DIV_M1;
                        end else begin
                            state    <= ST_IDLE;
                            baud_cnt <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// tb/tb_mfp_uart_transmitter.sv - self-checking bench for mfp_uart_transmitter
module tb_mfp_uart_transmitter;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 12_500_000;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int WAIT_LIMIT = 3000;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] exp_q [$];

    mfp_uart_transmitter #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .BAUD_RATE       (BAUD),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line level k cycles after the frame's first low cycle, from the 8N1 rules.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Offer a byte until accepted; an accepted byte enters the scoreboard.
    task automatic push_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        n        = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        forever begin
            rdy = tx_ready;
            step(1);
            if (rdy) begin
                exp_q.push_back(b);
                break;
            end
            n++;
            if (n >= WAIT_LIMIT) begin
                check("push_accept_timeout", 32'(n), 32'(WAIT_LIMIT - 1));
                break;
            end
        end
        tx_valid = 1'b0;
    endtask

    // Mid-bit sampling receiver; s is the cycle of the first low sample, -1 on timeout.
    task automatic rx_frame(output logic [7:0] d, output int s);
        int n;
        n = 0;
        d = 8'h00;
        s = -1;
        while (tx !== 1'b0 && n < WAIT_LIMIT) begin
            step(1);
            n++;
        end
        check("rx_start_seen", 32'(n < WAIT_LIMIT), 32'd1);
        if (n >= WAIT_LIMIT) return;
        s = cyc;
        step(DIV / 2);
        check("rx_start_mid", 32'(tx), 32'd0);
        step(DIV);
        for (int i = 0; i < 8; i++) begin
            d[i] = tx;
            if (i < 7) step(DIV);
        end
        step(DIV);
        check("rx_stop_bit", 32'(tx), 32'd1);
    endtask

    task automatic rx_expect(output int s);
        logic [7:0] d;
        rx_frame(d, s);
        if (s >= 0) begin
            check("rx_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("rx_byte", 32'(d), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic watch_idle(input int n, input string tag);
        logic low;
        low = 1'b0;
        repeat (n) begin
            step(1);
            if (tx !== 1'b1) low = 1'b1;
        end
        check(tag, 32'(low), 32'd0);
    endtask

    initial begin
        int s1, s2, s3, s;
        logic [7:0] full_bytes [6];
        full_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

        // Reset state, with a byte offered while reset is held.
        reset    = 1'b1;
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        step(3);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(tx_ready), 32'd1);
        reset    = 1'b0;
        tx_valid = 1'b0;
        step(1);
        check("reset_push_busy", 32'(busy), 32'd0);
        watch_idle(60, "reset_push_no_frame");

        // Single byte 0xA5: exact latency and per-cycle line level.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        check("a5_tx_edge_n", 32'(tx), 32'd1);
        check("a5_busy_edge_n", 32'(busy), 32'd1);
        step(1);
        check("a5_tx_edge_n1", 32'(tx), 32'd1);
        for (int k = 0; k < 10 * DIV; k++) begin
            step(1);
            check($sformatf("a5_bit_k%0d", k), 32'(tx), 32'(frame_bit(8'hA5, k)));
            if (k == 10 * DIV - 2) check("a5_busy_in_stop", 32'(busy), 32'd1);
        end
        check("a5_busy_after", 32'(busy), 32'd0);
        step(1);
        check("a5_tx_idle_after", 32'(tx), 32'd1);
        step(5);

        // Back-to-back frames with no idle gap.
        fork
            begin
                push_byte(8'h00);
                push_byte(8'hFF);
                push_byte(8'h55);
            end
            begin
                rx_expect(s1);
                rx_expect(s2);
                rx_expect(s3);
            end
        join
        check("b2b_gap_1", 32'(s2 - s1), 32'(10 * DIV));
        check("b2b_gap_2", 32'(s3 - s2), 32'(10 * DIV));
        step(10);
        check("b2b_busy_done", 32'(busy), 32'd0);

        // FIFO full with tx_valid held across six bytes.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push_byte(full_bytes[i]);
                    if (i == 4) check("full_ready_low", 32'(tx_ready), 32'd0);
                end
            end
            begin
                repeat (6) rx_expect(s);
            end
        join
        check("full_queue_drained", 32'(exp_q.size()), 32'd0);
        watch_idle(60, "full_no_extra_frame");
        check("full_busy_done", 32'(busy), 32'd0);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        push_byte(8'h3C);
        push_byte(8'hC3);
        push_byte(8'h81);
        s = 0;
        while (tx !== 1'b0 && s < WAIT_LIMIT) begin
            step(1);
            s++;
        end
        check("rst_mid_start_seen", 32'(s < WAIT_LIMIT), 32'd1);
        step(4 * DIV + 1);
        check("rst_mid_bit3", 32'(tx), 32'(frame_bit(8'h3C, 4 * DIV + 1)));
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_q.delete();
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        watch_idle(120, "rst_mid_no_frames");
        check("rst_mid_busy_end", 32'(busy), 32'd0);

        // Random bytes with random gaps against the scoreboard.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    step($urandom_range(0, 50));
                    push_byte(8'($urandom));
                end
            end
            begin
                repeat (8) rx_expect(s);
            end
        join
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
        step(10);
        check("rand_busy_done", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
